// File: rtl/multi_channel_sample_generator_pkg.sv
// Shared types, command field layout and LFSR tap table for the
// multi-channel DAC sample generator.
package multi_channel_sample_generator_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_RAND = 2'd1,
        MODE_TRIG = 2'd2,
        MODE_DC   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_SET_MODE   = 3'd1,
        OP_LOAD_SEED  = 3'd2,
        OP_SET_DC     = 3'd3,
        OP_SET_STEP   = 3'd4,
        OP_HALT_ALL   = 3'd5,
        OP_RESET_CHAN = 3'd6,
        OP_RSVD       = 3'd7
    } opcode_e;

    // Command word is {bcast, chan, op, payload}, payload in the LSBs.
    function automatic int chan_width(int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

    function automatic int cmd_op_lsb(int batch_width);
        return batch_width;
    endfunction

    function automatic int cmd_chan_lsb(int batch_width);
        return batch_width + 3;
    endfunction

    function automatic int cmd_bcast_bit(int num_channels, int batch_width);
        return batch_width + 3 + chan_width(num_channels);
    endfunction

    function automatic int cmd_width(int num_channels, int batch_width);
        return batch_width + 4 + chan_width(num_channels);
    endfunction

    // Right-shifting Galois feedback masks; 16 bits is x^16+x^14+x^13+x^11+1.
    function automatic logic [31:0] lfsr_taps(int sample_width);
        case (sample_width)
            4:       return 32'h0000_0009;
            8:       return 32'h0000_00B8;
            12:      return 32'h0000_0E08;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            32:      return 32'hA300_0000;
            default: return (32'd1 << (sample_width - 1)) | 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/multi_channel_sample_generator_if.sv
// Command, DAC output and status handshakes of the sample generator.
interface multi_channel_sample_generator_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int BATCH_SIZE   = 16
);
    import multi_channel_sample_generator_pkg::*;

    localparam int BW    = BATCH_SIZE * SAMPLE_WIDTH;
    localparam int CMD_W = cmd_width(NUM_CHANNELS, BW);

    logic [CMD_W-1:0]             cmd;
    logic                         cmd_valid;
    logic                         cmd_rdy;
    logic                         dac_rdy;
    logic [NUM_CHANNELS*BW-1:0]   dac_batch;
    logic [NUM_CHANNELS-1:0]      dac_batch_valid;
    logic [2*NUM_CHANNELS-1:0]    status;
    logic                         status_valid;
    logic                         status_rdy;

    modport master (
        output cmd, cmd_valid, dac_rdy, status_rdy,
        input  cmd_rdy, dac_batch, dac_batch_valid, status, status_valid
    );

    modport slave (
        input  cmd, cmd_valid, dac_rdy, status_rdy,
        output cmd_rdy, dac_batch, dac_batch_valid, status, status_valid
    );

endinterface

// File: rtl/multi_channel_sample_generator_wave_channel.sv
// One output channel: mode/seed/step/dc registers, per-lane LFSRs,
// triangle phase accumulator and the lane output mux.
module multi_channel_sample_generator_wave_channel
    import multi_channel_sample_generator_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BATCH_SIZE   = 16
) (
    input  logic                               clk,
    input  logic                               rst_in,
    input  logic                               adv,
    input  logic                               hit,
    input  logic                               halt,
    input  opcode_e                            op,
    input  logic [BATCH_SIZE*SAMPLE_WIDTH-1:0] payload,
    output mode_e                              mode,
    output mode_e                              mode_nxt,
    output logic [BATCH_SIZE*SAMPLE_WIDTH-1:0] batch,
    output logic                               valid
);
    localparam int SW = SAMPLE_WIDTH;
    localparam logic [31:0]   TAPS_ALL = lfsr_taps(SW);
    localparam logic [SW-1:0] TAPS     = TAPS_ALL[SW-1:0];

    logic [SW:0]   phase;
    logic [SW:0]   step;
    logic [SW-1:0] dc;
    logic [SW-1:0] lfsr [BATCH_SIZE];
    logic          chan_rst;

    assign chan_rst = hit && (op == OP_RESET_CHAN);

    always_comb begin
        mode_nxt = mode;
        if (halt || chan_rst)
            mode_nxt = MODE_OFF;
        else if (hit && (op == OP_SET_MODE))
            mode_nxt = mode_e'(payload[1:0]);
    end

    // Any SET_MODE write restarts the triangle; seeds, step and dc survive.
    always_ff @(posedge clk) begin
        if (rst_in || chan_rst) begin
            mode  <= MODE_OFF;
            phase <= '0;
            step  <= (SW+1)'(1);
            dc    <= '0;
            for (int j = 0; j < BATCH_SIZE; j++)
                lfsr[j] <= SW'(j + 1);
        end else begin
            mode <= mode_nxt;
            if (halt || (hit && (op == OP_SET_MODE)))
                phase <= '0;
            else if (adv && (mode == MODE_TRIG))
                phase <= phase + step * (SW+1)'(BATCH_SIZE);
            for (int j = 0; j < BATCH_SIZE; j++) begin
                if (hit && (op == OP_LOAD_SEED))
                    lfsr[j] <= (payload[j*SW +: SW] == '0) ? SW'(1) : payload[j*SW +: SW];
                else if (adv && (mode == MODE_RAND))
                    lfsr[j] <= {1'b0, lfsr[j][SW-1:1]} ^ (lfsr[j][0] ? TAPS : '0);
            end
            if (hit && (op == OP_SET_DC))
                dc <= payload[SW-1:0];
            if (hit && (op == OP_SET_STEP))
                step <= payload[SW:0];
        end
    end

    logic [SW:0] q;

    // NOTE: every always_comb output and temporary is defaulted before the
    // loop, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        batch = '0;
        q     = '0;
        for (int j = 0; j < BATCH_SIZE; j++) begin
            q = phase + (SW+1)'(j) * step;
            case (mode)
                MODE_RAND: batch[j*SW +: SW] = lfsr[j];
                MODE_TRIG: batch[j*SW +: SW] = q[SW] ? ~q[SW-1:0] : q[SW-1:0];
                MODE_DC:   batch[j*SW +: SW] = dc;
                default:   batch[j*SW +: SW] = '0;
            endcase
        end
    end

    assign valid = (mode != MODE_OFF);

endmodule

// File: rtl/multi_channel_sample_generator.sv
// Command decode, status handshake and per-channel DAC output pipelines
// around NUM_CHANNELS independent wave channels.
module multi_channel_sample_generator
    import multi_channel_sample_generator_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int BATCH_SIZE   = 16,
    parameter int DAC_STAGES   = 5
) (
    input logic                           clk,
    input logic                           rst_in,
    multi_channel_sample_generator_if.slave bus
);
    localparam int BW        = BATCH_SIZE * SAMPLE_WIDTH;
    localparam int CH_W      = chan_width(NUM_CHANNELS);
    localparam int OP_LSB    = cmd_op_lsb(BW);
    localparam int CHAN_LSB  = cmd_chan_lsb(BW);
    localparam int BCAST_BIT = cmd_bcast_bit(NUM_CHANNELS, BW);

    logic              load_hold;
    logic              accept;
    logic              halt;
    logic              bcast;
    logic              adv;
    logic              mode_change;
    logic              status_valid;
    opcode_e           op;
    logic [CH_W-1:0]   chan;
    logic [BW-1:0]     payload;

    logic [NUM_CHANNELS-1:0] hit;
    logic [NUM_CHANNELS-1:0] flush;
    logic [NUM_CHANNELS-1:0] ch_valid;
    mode_e                   ch_mode     [NUM_CHANNELS];
    mode_e                   ch_mode_nxt [NUM_CHANNELS];
    logic [BW-1:0]           ch_batch    [NUM_CHANNELS];
    logic [BW:0]             pipe        [NUM_CHANNELS][DAC_STAGES];

    assign op      = opcode_e'(bus.cmd[OP_LSB +: 3]);
    assign chan    = bus.cmd[CHAN_LSB +: CH_W];
    assign bcast   = bus.cmd[BCAST_BIT];
    assign payload = bus.cmd[BW-1:0];

    assign bus.cmd_rdy = !load_hold;
    assign accept      = bus.cmd_valid && !load_hold;
    assign halt        = accept && (op == OP_HALT_ALL);
    assign adv         = bus.dac_rdy && !load_hold;

    always_comb begin
        hit         = '0;
        flush       = '0;
        mode_change = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            hit[c]   = accept && (bcast || (chan == CH_W'(c)));
            flush[c] = hit[c] && (op == OP_RESET_CHAN);
            if (ch_mode_nxt[c] != ch_mode[c])
                mode_change = 1'b1;
        end
    end

    // The cycle after an accepted LOAD_SEED blocks commands and freezes the generators.
    always_ff @(posedge clk) begin
        if (rst_in)
            load_hold <= 1'b0;
        else
            load_hold <= accept && (op == OP_LOAD_SEED);
    end

    always_ff @(posedge clk) begin
        if (rst_in)
            status_valid <= 1'b0;
        else if (mode_change)
            status_valid <= 1'b1;
        else if (bus.status_rdy)
            status_valid <= 1'b0;
    end

    assign bus.status_valid = status_valid;

    // NOTE: these stages are ordinary flops, not a RAM, so they take the
    // reset; HALT_ALL and RESET_CHAN reuse the same same-edge clear.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rst_in || halt || flush[c]) begin
                for (int s = 0; s < DAC_STAGES; s++)
                    pipe[c][s] <= '0;
            end else if (bus.dac_rdy) begin
                pipe[c][0] <= {ch_valid[c], ch_batch[c]};
                for (int s = 1; s < DAC_STAGES; s++)
                    pipe[c][s] <= pipe[c][s-1];
            end
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        multi_channel_sample_generator_wave_channel #(
            .SAMPLE_WIDTH (SAMPLE_WIDTH),
            .BATCH_SIZE   (BATCH_SIZE)
        ) u_wave (
            .clk      (clk),
            .rst_in   (rst_in),
            .adv      (adv),
            .hit      (hit[c]),
            .halt     (halt),
            .op       (op),
            .payload  (payload),
            .mode     (ch_mode[c]),
            .mode_nxt (ch_mode_nxt[c]),
            .batch    (ch_batch[c]),
            .valid    (ch_valid[c])
        );

        assign bus.dac_batch[c*BW +: BW]  = bus.dac_rdy ? pipe[c][DAC_STAGES-1][BW-1:0] : '0;
        assign bus.dac_batch_valid[c]     = bus.dac_rdy & pipe[c][DAC_STAGES-1][BW];
        assign bus.status[2*c +: 2]       = ch_mode[c];
    end

endmodule

// File: tb/tb_multi_channel_sample_generator.sv
// Directed bench for multi_channel_sample_generator with a per-cycle
// behavioural reference model and hand-computed literal checkpoints.
module tb_multi_channel_sample_generator;

    localparam int NCH   = 2;
    localparam int SW    = 16;
    localparam int BS    = 16;
    localparam int STG   = 5;
    localparam int BW    = BS * SW;
    localparam int CMD_W = BW + 5;

    localparam int OP_SET_MODE = 1, OP_LOAD_SEED = 2, OP_SET_DC = 3;
    localparam int OP_SET_STEP = 4, OP_HALT_ALL = 5, OP_RESET_CHAN = 6;

    logic clk = 1'b0;
    logic rst_in;

    multi_channel_sample_generator_if #(
        .NUM_CHANNELS (NCH),
        .SAMPLE_WIDTH (SW),
        .BATCH_SIZE   (BS)
    ) bus ();

    multi_channel_sample_generator #(
        .NUM_CHANNELS (NCH),
        .SAMPLE_WIDTH (SW),
        .BATCH_SIZE   (BS),
        .DAC_STAGES   (STG)
    ) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mode  [NCH];
    int          m_phase [NCH];
    int          m_step  [NCH];
    int          m_dc    [NCH];
    int          m_lfsr  [NCH][BS];
    logic [BW:0] m_pipe  [NCH][$];
    bit          m_hold;
    bit          m_sv;
    bit          model_ready = 1'b0;

    function automatic int fold_val(input int q_in);
        int q = q_in % 131072;
        return (q >= 65536) ? (131071 - q) : q;
    endfunction

    function automatic int lfsr_next(input int s);
        return (s >> 1) ^ (((s & 1) != 0) ? 'hB400 : 0);
    endfunction

    function automatic logic [BW:0] gen_batch(input int c);
        logic [BW:0] b = '0;
        int v;
        for (int j = 0; j < BS; j++) begin
            case (m_mode[c])
                1:       v = m_lfsr[c][j];
                2:       v = fold_val(m_phase[c] + j * m_step[c]);
                3:       v = m_dc[c];
                default: v = 0;
            endcase
            b[j*SW +: SW] = 16'(v);
        end
        b[BW] = (m_mode[c] != 0);
        return b;
    endfunction

    task automatic model_reset_chan(input int c);
        m_mode[c]  = 0;
        m_phase[c] = 0;
        m_step[c]  = 1;
        m_dc[c]    = 0;
        for (int j = 0; j < BS; j++) m_lfsr[c][j] = j + 1;
        m_pipe[c].delete();
        for (int s = 0; s < STG; s++) m_pipe[c].push_back('0);
    endtask

    task automatic model_step();
        logic [BW:0]   cur      [NCH];
        int            old_mode [NCH];
        logic [BW-1:0] pl;
        bit            acc, bc, halt, hit, changed;
        int            ch, op, seed;
        if (rst_in) begin
            for (int c = 0; c < NCH; c++) model_reset_chan(c);
            m_hold      = 1'b0;
            m_sv        = 1'b0;
            model_ready = 1'b1;
        end else begin
            acc  = bus.cmd_valid && !m_hold;
            bc   = bus.cmd[BW+4];
            ch   = int'(bus.cmd[BW+3]);
            op   = int'(bus.cmd[BW+2:BW]);
            pl   = bus.cmd[BW-1:0];
            halt = acc && (op == OP_HALT_ALL);
            for (int c = 0; c < NCH; c++) begin
                cur[c]      = gen_batch(c);
                old_mode[c] = m_mode[c];
            end
            for (int c = 0; c < NCH; c++) begin
                hit = acc && (bc || ch == c);
                if (bus.dac_rdy && !m_hold) begin
                    if (m_mode[c] == 2) m_phase[c] = (m_phase[c] + BS * m_step[c]) % 131072;
                    if (m_mode[c] == 1)
                        for (int j = 0; j < BS; j++) m_lfsr[c][j] = lfsr_next(m_lfsr[c][j]);
                end
                if (halt) begin
                    m_pipe[c].delete();
                    for (int s = 0; s < STG; s++) m_pipe[c].push_back('0);
                end else if (bus.dac_rdy) begin
                    m_pipe[c].push_front(cur[c]);
                    void'(m_pipe[c].pop_back());
                end
                if (hit) begin
                    case (op)
                        OP_SET_MODE: begin m_mode[c] = int'(pl[1:0]); m_phase[c] = 0; end
                        OP_LOAD_SEED:
                            for (int j = 0; j < BS; j++) begin
                                seed = int'(pl[j*SW +: SW]);
                                m_lfsr[c][j] = (seed == 0) ? 1 : seed;
                            end
                        OP_SET_DC:     m_dc[c]   = int'(pl[SW-1:0]);
                        OP_SET_STEP:   m_step[c] = int'(pl[SW:0]);
                        OP_RESET_CHAN: model_reset_chan(c);
                        default: ;
                    endcase
                end
                if (halt) begin
                    m_mode[c]  = 0;
                    m_phase[c] = 0;
                end
            end
            m_hold  = acc && (op == OP_LOAD_SEED);
            changed = 1'b0;
            for (int c = 0; c < NCH; c++) if (m_mode[c] != old_mode[c]) changed = 1'b1;
            if (changed) m_sv = 1'b1;
            else if (bus.status_rdy) m_sv = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (model_ready) begin
            logic [BW:0]       exp;
            logic [2*NCH-1:0]  exp_status;
            for (int c = 0; c < NCH; c++) begin
                exp = bus.dac_rdy ? m_pipe[c][STG-1] : '0;
                check($sformatf("model ch%0d batch", c), bus.dac_batch[c*BW +: BW], exp[BW-1:0]);
                check($sformatf("model ch%0d valid", c), bus.dac_batch_valid[c], exp[BW]);
                exp_status[2*c +: 2] = 2'(m_mode[c]);
            end
            check("model status", bus.status, exp_status);
            check("model status_valid", bus.status_valid, m_sv);
            check("model cmd_rdy", bus.cmd_rdy, !m_hold);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input bit bc, input int ch, input int op, input logic [BW-1:0] pl);
        bit ok = 1'b0;
        bus.cmd       = {bc, 1'(ch), 3'(op), pl};
        bus.cmd_valid = 1'b1;
        for (int n = 0; n < 8 && !ok; n++) begin
            ok = bus.cmd_rdy;
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("cmd accepted within bound", ok, 1'b1);
    endtask

    function automatic logic [BW-1:0] lanes_all(input logic [SW-1:0] v);
        logic [BW-1:0] b;
        for (int j = 0; j < BS; j++) b[j*SW +: SW] = v;
        return b;
    endfunction

    function automatic logic [BW-1:0] lanes_ramp(input int base, input int inc);
        logic [BW-1:0] b;
        for (int j = 0; j < BS; j++) b[j*SW +: SW] = 16'(base + j * inc);
        return b;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, time %0t limit 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in         = 1'b1;
        bus.cmd        = '0;
        bus.cmd_valid  = 1'b0;
        bus.dac_rdy    = 1'b1;
        bus.status_rdy = 1'b1;
        ticks(2);
        rst_in = 1'b0;
        check("reset cmd_rdy", bus.cmd_rdy, 1'b1);
        check("reset dac_batch", bus.dac_batch, '0);
        check("reset dac_batch_valid", bus.dac_batch_valid, 2'b00);
        check("reset status", bus.status, 4'h0);
        check("reset status_valid", bus.status_valid, 1'b0);

        // Triangle with step 4096 on both channels: rising then folded batch.
        send(1'b1, 0, OP_SET_STEP, BW'(4096));
        send(1'b1, 0, OP_SET_MODE, BW'(2));
        ticks(5);
        check("trig first batch ch0", bus.dac_batch[BW-1:0], lanes_ramp(0, 4096));
        check("trig first batch ch1", bus.dac_batch[2*BW-1:BW], lanes_ramp(0, 4096));
        tick();
        check("trig folded batch ch0", bus.dac_batch[BW-1:0], lanes_ramp(65535, -4096));

        // ch1 DC level, ch0 off.
        send(1'b0, 1, OP_SET_DC, BW'(16'h1234));
        send(1'b0, 1, OP_SET_MODE, BW'(3));
        send(1'b0, 0, OP_SET_MODE, BW'(0));
        ticks(6);
        check("dc ch1 lanes", bus.dac_batch[2*BW-1:BW], lanes_all(16'h1234));
        check("dc valid vector", bus.dac_batch_valid, 2'b10);
        check("off ch0 batch", bus.dac_batch[BW-1:0], '0);

        // Zero seed load becomes 1 in every lane; then RAND.
        send(1'b0, 0, OP_LOAD_SEED, '0);
        check("seed load cycle cmd_rdy low", bus.cmd_rdy, 1'b0);
        tick();
        check("cmd_rdy back after seed load", bus.cmd_rdy, 1'b1);
        send(1'b0, 0, OP_SET_MODE, BW'(1));
        ticks(5);
        check("rand batch 0", bus.dac_batch[BW-1:0], lanes_all(16'h0001));
        tick();
        check("rand batch 1", bus.dac_batch[BW-1:0], lanes_all(16'hB400));
        bus.dac_rdy = 1'b0;
        ticks(2);
        check("rand stalled output zero", bus.dac_batch[BW-1:0], '0);
        bus.dac_rdy = 1'b1;
        #1;
        check("rand held across stall", bus.dac_batch[BW-1:0], lanes_all(16'hB400));
        tick();
        check("rand batch 2", bus.dac_batch[BW-1:0], lanes_all(16'h5A00));

        // Step-1 triangle on ch0 with dac_rdy pattern 1,0,0,1.
        send(1'b0, 0, OP_SET_STEP, BW'(1));
        send(1'b0, 0, OP_SET_MODE, BW'(2));
        ticks(5);
        check("trig step1 batch 0", bus.dac_batch[BW-1:0], lanes_ramp(0, 1));
        tick();
        check("trig step1 batch 1", bus.dac_batch[BW-1:0], lanes_ramp(16, 1));
        bus.dac_rdy = 1'b0;
        tick();
        check("stall 1 output zero", bus.dac_batch, '0);
        tick();
        check("stall 2 valid zero", bus.dac_batch_valid, 2'b00);
        bus.dac_rdy = 1'b1;
        #1;
        check("resume no skip", bus.dac_batch[BW-1:0], lanes_ramp(16, 1));
        tick();
        check("resume batch 2", bus.dac_batch[BW-1:0], lanes_ramp(32, 1));
        tick();
        check("resume batch 3", bus.dac_batch[BW-1:0], lanes_ramp(48, 1));

        // Status held pending while the consumer is not ready.
        tick();
        bus.status_rdy = 1'b0;
        send(1'b0, 0, OP_SET_MODE, BW'(1));
        send(1'b0, 0, OP_SET_MODE, BW'(3));
        check("status pending", bus.status_valid, 1'b1);
        check("status shows DC on both", bus.status, 4'hF);
        tick();
        check("status still pending", bus.status_valid, 1'b1);
        bus.status_rdy = 1'b1;
        tick();
        bus.status_rdy = 1'b0;
        check("status consumed", bus.status_valid, 1'b0);
        bus.status_rdy = 1'b1;

        // HALT_ALL flushes all pipelines at once.
        send(1'b0, 1, OP_HALT_ALL, '0);
        check("halt batch zero", bus.dac_batch, '0);
        check("halt valid zero", bus.dac_batch_valid, 2'b00);
        check("halt status off", bus.status, 4'h0);
        ticks(6);

        // Reset concurrent with a command: reset wins.
        send(1'b0, 1, OP_SET_MODE, BW'(3));
        ticks(6);
        rst_in        = 1'b1;
        bus.cmd       = {1'b1, 1'b0, 3'(OP_SET_MODE), BW'(1)};
        bus.cmd_valid = 1'b1;
        check("cmd_rdy during reset", bus.cmd_rdy, 1'b1);
        tick();
        rst_in        = 1'b0;
        bus.cmd_valid = 1'b0;
        check("post-reset status", bus.status, 4'h0);
        check("post-reset status_valid", bus.status_valid, 1'b0);
        check("post-reset batch", bus.dac_batch, '0);
        ticks(6);
        check("post-reset valid stays 0", bus.dac_batch_valid, 2'b00);
        check("post-reset status_valid stays 0", bus.status_valid, 1'b0);

        // RESET_CHAN restores step 1 and seeds; then a quick triangle.
        send(1'b0, 0, OP_SET_STEP, BW'(7));
        send(1'b0, 0, OP_RESET_CHAN, '0);
        send(1'b0, 0, OP_SET_MODE, BW'(2));
        ticks(5);
        check("reset_chan step back to 1", bus.dac_batch[BW-1:0], lanes_ramp(0, 1));
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
